// File: rtl/l2_cache_update_pkg.sv
// l2_cache_update_pkg: L2 widths, request op encodings and the pipeline request bundle.
package l2_cache_update_pkg;
    localparam int L2_TAG_WIDTH        = 18;
    localparam int L2_SET_INDEX_WIDTH  = 8;
    localparam int L2_WAY_WIDTH        = 2;
    localparam int L2_CACHE_ADDR_WIDTH = L2_WAY_WIDTH + L2_SET_INDEX_WIDTH;
    localparam int L2_ADDR_WIDTH       = L2_TAG_WIDTH + L2_SET_INDEX_WIDTH;
    localparam int L2_LINE_BYTES       = 64;
    localparam int L2_LINE_WIDTH       = L2_LINE_BYTES * 8;

    typedef enum logic [2:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_DINVALIDATE = 3'd3,
        L2REQ_IINVALIDATE = 3'd4,
        L2REQ_LOAD_SYNC   = 3'd5,
        L2REQ_STORE_SYNC  = 3'd6
    } l2req_op_t;

    typedef struct packed {
        logic                     valid;
        logic [1:0]               core;
        logic [1:0]               unit;
        logic [1:0]               strand;
        logic [2:0]               op;
        logic [L2_ADDR_WIDTH-1:0] address;
        logic                     store_sync_success;
    } l2req_t;
endpackage

// File: rtl/l2_writeback_fifo.sv
// l2_writeback_fifo: small circular FIFO holding dirty lines until system memory accepts them.
module l2_writeback_fifo #(
    parameter int WIDTH = 538,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = full_q;
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot, so a push is accepted even when full.
    assign do_push = push_i && (!full_q || do_pop);
    assign count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    assign data_o  = empty_o ? '0 : mem_q[head_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_pop) head_q <= head_q + 1'b1;
            if (do_push) tail_q <= tail_q + 1'b1;
            count_q <= count_d;
            full_q  <= count_d == FULL_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= data_i;
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(push_i && full_q && !do_pop));
endmodule

// File: rtl/l2_cache_update.sv
// l2_cache_update: merges store/fill data into the read line, drives the SRAM write port
// one cycle later and queues dirty victims or flushed lines for writeback.
module l2_cache_update
    import l2_cache_update_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           stall_pipeline,
    input  logic                           rd_l2req_valid,
    input  logic [1:0]                     rd_l2req_core,
    input  logic [1:0]                     rd_l2req_unit,
    input  logic [1:0]                     rd_l2req_strand,
    input  logic [2:0]                     rd_l2req_op,
    input  logic [L2_ADDR_WIDTH-1:0]       rd_l2req_address,
    input  logic [L2_LINE_WIDTH-1:0]       rd_l2req_data,
    input  logic [L2_LINE_BYTES-1:0]       rd_l2req_mask,
    input  logic                           rd_has_sm_data,
    input  logic [L2_LINE_WIDTH-1:0]       rd_sm_data,
    input  logic                           rd_cache_hit,
    input  logic [L2_WAY_WIDTH-1:0]        rd_hit_l2_way,
    input  logic [L2_WAY_WIDTH-1:0]        rd_sm_fill_l2_way,
    input  logic [L2_TAG_WIDTH-1:0]        rd_old_l2_tag,
    input  logic                           rd_line_is_dirty,
    input  logic                           rd_store_sync_success,
    input  logic [L2_LINE_WIDTH-1:0]       rd_cache_mem_result,
    output logic                           wr_update_l2_data,
    output logic [L2_CACHE_ADDR_WIDTH-1:0] wr_cache_write_index,
    output logic [L2_LINE_WIDTH-1:0]       wr_update_data,
    output logic                           wr_l2req_valid,
    output logic [1:0]                     wr_l2req_core,
    output logic [1:0]                     wr_l2req_unit,
    output logic [1:0]                     wr_l2req_strand,
    output logic [2:0]                     wr_l2req_op,
    output logic [L2_ADDR_WIDTH-1:0]       wr_l2req_address,
    output logic                           wr_store_sync_success,
    output logic [L2_LINE_WIDTH-1:0]       wr_data,
    output logic                           wb_valid,
    output logic [L2_ADDR_WIDTH-1:0]       wb_address,
    output logic [L2_LINE_WIDTH-1:0]       wb_data,
    input  logic                           wb_ready,
    output logic                           wb_full
);
    logic [L2_LINE_WIDTH-1:0]       base, new_line, line_q;
    logic [L2_SET_INDEX_WIDTH-1:0]  set_idx;
    logic [L2_WAY_WIDTH-1:0]        way;
    logic [L2_ADDR_WIDTH-1:0]       wb_addr_in;
    logic [L2_CACHE_ADDR_WIDTH-1:0] idx_q;
    logic                           store_commit, write_en, wb_push, upd_q, wb_empty;
    l2req_t                         req_d, req_q;

    assign base         = rd_has_sm_data ? rd_sm_data : rd_cache_mem_result;
    assign store_commit = rd_l2req_op == L2REQ_STORE
                       || (rd_l2req_op == L2REQ_STORE_SYNC && rd_store_sync_success);
    assign write_en     = rd_l2req_valid && (rd_has_sm_data || (rd_cache_hit && store_commit));
    assign set_idx      = rd_l2req_address[L2_SET_INDEX_WIDTH-1:0];
    assign way          = rd_cache_hit ? rd_hit_l2_way : rd_sm_fill_l2_way;

    for (genvar b = 0; b < L2_LINE_BYTES; b++) begin : g_merge
        assign new_line[8*b +: 8] = (store_commit && rd_l2req_mask[b]) ? rd_l2req_data[8*b +: 8]
                                                                       : base[8*b +: 8];
    end

    assign req_d = '{valid: rd_l2req_valid, core: rd_l2req_core, unit: rd_l2req_unit,
                     strand: rd_l2req_strand, op: rd_l2req_op, address: rd_l2req_address,
                     store_sync_success: rd_store_sync_success};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= '0;
            upd_q <= 1'b0;
            idx_q <= '0;
            line_q <= '0;
        end else if (!stall_pipeline) begin
            req_q <= req_d;
            upd_q <= write_en;
            idx_q <= {way, set_idx};
            line_q <= new_line;
        end
    end

    assign wr_update_l2_data     = upd_q;
    assign wr_cache_write_index  = idx_q;
    assign wr_update_data        = line_q;
    assign wr_data               = line_q;
    assign wr_l2req_valid        = req_q.valid;
    assign wr_l2req_core         = req_q.core;
    assign wr_l2req_unit         = req_q.unit;
    assign wr_l2req_strand       = req_q.strand;
    assign wr_l2req_op           = req_q.op;
    assign wr_l2req_address      = req_q.address;
    assign wr_store_sync_success = req_q.store_sync_success;

    // Victim data is the SRAM read result, captured before this stage overwrites it.
    assign wb_push    = rd_l2req_valid && !stall_pipeline && rd_line_is_dirty
                     && ((!rd_cache_hit && rd_has_sm_data) || (rd_l2req_op == L2REQ_FLUSH && rd_cache_hit));
    assign wb_addr_in = rd_cache_hit ? rd_l2req_address : {rd_old_l2_tag, set_idx};
    assign wb_valid   = !wb_empty;

    l2_writeback_fifo #(
        .WIDTH(L2_ADDR_WIDTH + L2_LINE_WIDTH),
        .DEPTH(WB_FIFO_DEPTH)
    ) u_wb_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push_i (wb_push),
        .data_i ({wb_addr_in, rd_cache_mem_result}),
        .pop_i  (wb_ready),
        .data_o ({wb_address, wb_data}),
        .full_o (wb_full),
        .empty_o(wb_empty)
    );
endmodule
